// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// Data-memory responder for the multi-cycle RV32 core. It holds a word-organised
// RAM behind a request/acknowledge handshake, inserts WAIT_CYCLES wait states
// before every access and flags misaligned or out-of-range byte addresses.
//
// Parameters
//   ADDR_WIDTH  : word-index width, RAM depth = 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES : wait states before each access (0..15)
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   req    in   access request, sampled only while idle
//   we     in   1 = store, 0 = load, sampled with req
//   addr   in   32-bit byte address
//   wdata  in   store data
//   wstrb  in   store byte enables (bit i -> wdata[8i+7:8i]), ignored for loads
//   rdata  out  load data, valid while ack=1
//   ack    out  one-cycle completion pulse
//   err    out  access error, valid while ack=1
//   busy   out  high from request capture until the cycle after ack
// -----------------------------------------------------------------------------
module data_mem_resp #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // An address faults when it is not word aligned or when it points beyond
    // the RAM (any byte-address bit above the word index is set).
    function automatic logic addr_fault(input logic [31:0] a);
        logic misaligned_s;
        logic out_of_range_s;
        misaligned_s   = (a[1:0] != 2'd0);
        out_of_range_s = ((a >> (ADDR_WIDTH + 2)) != 32'd0);
        return misaligned_s | out_of_range_s;
    endfunction

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic                    fault_r;
    logic                    we_r;
    logic [31:0]             wdata_r;
    logic [3:0]              wstrb_r;

    logic [31:0]             mem_r [DEPTH];

    logic                    access_s;
    logic                    mem_wr_s;

    // Access edge: last wait state reached; a store only writes when error-free.
    always_comb begin
        access_s = 1'b0;
        mem_wr_s = 1'b0;
        if ((state_r == ST_WAIT) && (cnt_r == 4'd0)) begin
            access_s = 1'b1;
            mem_wr_s = we_r & ~fault_r;
        end else begin
            access_s = 1'b0;
            mem_wr_s = 1'b0;
        end
    end

    // RAM byte-lane write port; contents are deliberately never reset. While
    // rst is low the FSM sits in IDLE, so an aborted store never writes.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM: request capture, wait-state countdown, one-cycle response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            fault_r <= 1'b0;
            we_r    <= 1'b0;
            wdata_r <= 32'd0;
            wstrb_r <= 4'd0;
            rdata   <= 32'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    rdata <= 32'd0;
                    if (req) begin
                        // The fault check is resolved at capture so only the
                        // word index and one flag need to be held.
                        idx_r   <= addr[ADDR_WIDTH+1:2];
                        fault_r <= addr_fault(addr);
                        we_r    <= we;
                        wdata_r <= wdata;
                        wstrb_r <= wstrb;
                        cnt_r   <= WAIT_LOAD;
                        busy    <= 1'b1;
                        state_r <= ST_WAIT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!access_s) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        ack     <= 1'b1;
                        err     <= fault_r;
                        // Stores and faulted accesses return zero data.
                        if (!fault_r && !we_r) begin
                            rdata <= mem_r[idx_r];
                        end else begin
                            rdata <= 32'd0;
                        end
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    rdata   <= 32'd0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    rdata   <= 32'd0;
                    busy    <= 1'b0;
                    cnt_r   <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_data_mem_resp
// Drives two responders (WAIT_CYCLES=0 and WAIT_CYCLES=2) sharing clk and rst.
// Expected results come from a word-array model of each RAM updated with the
// access rules (alignment/range error, byte-lane stores) and from the handshake
// timing arithmetic (ack W+1 cycles after capture, busy W+2 cycles, period W+3).
// Index 0 selects the zero-wait instance, index 1 the two-wait instance.
// -----------------------------------------------------------------------------
module tb_data_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, req2, we2;
    logic [31:0] addr0, wdata0, addr2, wdata2;
    logic [3:0]  wstrb0, wstrb2;
    wire  [31:0] rdata0, rdata2;
    wire         ack0, err0, busy0, ack2, err2, busy2;

    data_mem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .wstrb(wstrb0), .rdata(rdata0), .ack(ack0),
        .err(err0), .busy(busy0)
    );

    data_mem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .wstrb(wstrb2), .rdata(rdata2), .ack(ack2),
        .err(err2), .busy(busy2)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [2][256];

    function automatic int wait_of(input int sel);
        return (sel != 0) ? 2 : 0;
    endfunction

    function automatic logic get_ack(input int sel);
        return (sel != 0) ? ack2 : ack0;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel != 0) ? err2 : err0;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy2 : busy0;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel != 0) ? rdata2 : rdata0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (sel != 0) begin
            req2 = r; we2 = w; addr2 = a; wdata2 = d; wstrb2 = s;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d; wstrb0 = s;
        end
    endtask

    task automatic set_req(input int sel, input logic r);
        if (sel != 0) req2 = r;
        else          req0 = r;
    endtask

    // Reference model: 256 words, 1 KiB of byte address space.
    task automatic model(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic e);
        int idx;
        e  = ((a % 4) != 0) || (a >= 32'h0000_0400);
        rd = 32'd0;
        if (!e) begin
            idx = int'(a / 4);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) ref_mem[sel][idx][8*i +: 8] = d[8*i +: 8];
            end else begin
                rd = ref_mem[sel][idx];
            end
        end
    endtask

    // One transaction; called at a negedge, returns at the negedge after the
    // response cycle (the earliest point a next request can be presented).
    task automatic txn(input int sel, input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_e;
        int          k;
        int          busy_n;
        bit          seen;
        model(sel, w, a, d, s, exp_rd, exp_e);
        drive(sel, 1'b1, w, a, d, s);
        @(posedge clk);
        @(negedge clk);
        // Inputs change mid-transaction; req stays high until the ack cycle.
        drive(sel, 1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom));
        k = 0; busy_n = 0; seen = 1'b0; got = 32'd0;
        chk({tag, "_busy_rise"}, 32'(get_busy(sel)), 32'd1);
        while (!seen && k < 40) begin
            if (get_busy(sel)) busy_n++;
            if (get_ack(sel)) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        set_req(sel, 1'b0);
        chk({tag, "_latency"}, 32'(k), 32'(wait_of(sel) + 1));
        got = get_rdata(sel);
        chk({tag, "_err"}, 32'(get_err(sel)), 32'(exp_e));
        chk({tag, "_rdata"}, got, exp_rd);
        @(negedge clk);
        chk({tag, "_busy_len"}, 32'(busy_n), 32'(wait_of(sel) + 2));
        chk({tag, "_ack_drop"}, {29'd0, get_ack(sel), get_busy(sel), get_err(sel)}, 32'd0);
        chk({tag, "_rdata_clr"}, get_rdata(sel), 32'd0);
    endtask

    // req held high for hold_n capture opportunities: captures every W+3 edges.
    task automatic hold_req(input int sel, input string tag, input int hold_n);
        int p, n, first, last, exp_n;
        p = wait_of(sel) + 3;
        exp_n = (hold_n + p - 1) / p;
        n = 0; first = -1; last = 0;
        drive(sel, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 4'd0);
        for (int e = 0; e < hold_n + 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == hold_n - 1) set_req(sel, 1'b0);
            if (get_ack(sel)) begin
                chk({tag, "_rdata"}, get_rdata(sel), ref_mem[sel][4]);
                if (n == 0) first = e;
                else chk({tag, "_spacing"}, 32'(e - last), 32'(p));
                last = e;
                n++;
            end
        end
        chk({tag, "_count"}, 32'(n), 32'(exp_n));
        chk({tag, "_first"}, 32'(first), 32'(wait_of(sel) + 1));
    endtask

    logic [31:0] got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        chk("reset_out0", {rdata0[28:0], ack0, err0, busy0} | {29'd0, 3'd0} | 32'(rdata0 != 32'd0), 32'd0);
        chk("reset_out2", {rdata2[28:0], ack2, err2, busy2} | 32'(rdata2 != 32'd0), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Known contents for the low 16 words of both RAMs.
        for (int sel = 0; sel < 2; sel++)
            for (int i = 0; i < 16; i++)
                txn(sel, "init", 1'b1, 32'(i * 4), 32'd0, 4'hF, got);

        // Load after store.
        txn(1, "st_beef", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, got);
        txn(1, "ld_beef", 1'b0, 32'h10, 32'd0, 4'h0, got);
        chk("ld_beef_const", got, 32'hDEAD_BEEF);

        // Byte-lane write.
        txn(1, "st_lane_a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, got);
        txn(1, "st_lane_b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, got);
        txn(1, "st_lane_z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, got);
        txn(1, "ld_lane", 1'b0, 32'h20, 32'd0, 4'h0, got);
        chk("ld_lane_const", got, 32'h11BB_33DD);

        // Error cases.
        txn(1, "ld_misalign", 1'b0, 32'h13, 32'd0, 4'h0, got);
        txn(1, "st_range", 1'b1, 32'h400, 32'h5A5A_5A5A, 4'hF, got);
        txn(1, "ld_zero", 1'b0, 32'h000, 32'd0, 4'h0, got);
        chk("ld_zero_const", got, 32'h0000_0000);

        // Randomized accesses against the model, back to back.
        for (int sel = 0; sel < 2; sel++) begin
            for (int t = 0; t < 40; t++) begin
                logic [31:0] a;
                int r;
                a = 32'($urandom_range(0, 15) * 4);
                r = int'($urandom_range(0, 7));
                if (r == 0)      a = a + 32'($urandom_range(1, 3));
                else if (r == 1) a = a | (32'd1 << $urandom_range(10, 31));
                txn(sel, "rand", 1'($urandom), a, $urandom, 4'($urandom), got);
            end
        end

        // Held request and zero-wait back-to-back.
        hold_req(1, "hold2", 12);
        hold_req(0, "hold0", 7);
        txn(0, "zw_load", 1'b0, 32'h10, 32'd0, 4'h0, got);

        // Reset in the middle of a store.
        txn(1, "st_pre", 1'b1, 32'h30, 32'h0102_0304, 4'hF, got);
        drive(1, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0);
        chk("mid_busy", 32'(busy2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_flags", {29'd0, ack2, busy2, err2}, 32'd0);
        chk("mid_rst_rdata", rdata2, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(1, "ld_after_rst", 1'b0, 32'h30, 32'd0, 4'h0, got);
        chk("ld_after_rst_const", got, 32'h0102_0304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
